lcd_8080_writer: RTL and testbench

- Avalon-MM slave that turns Nios II register writes into 8080-style parallel write cycles for the 24-bit TFT LCD.
- Drives lcd_cs, lcd_data, lcd_dc, lcd_rst and lcd_wr.
- Buffers command and data words in a small FIFO so software can post bursts without polling each word.
- Generates the panel hardware-reset pulse after system reset and on software request.

---
 rtl/lcd_8080_writer.sv | 182 ++++++++++++++++++
 tb/tb_lcd_8080_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_8080_writer.sv
// Avalon-MM slave that queues command/data words and plays them out as
// 8080-style parallel write cycles, plus the panel hardware-reset pulse.
module lcd_8080_writer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int RST_CYCLES     = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        lcd_cs,
  output logic [23:0] lcd_data,
  output logic        lcd_dc,
  output logic        lcd_rst,
  output logic        lcd_wr
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MAXC_A = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int MAXC   = (RST_CYCLES > MAXC_A) ? RST_CYCLES : MAXC_A;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HI_LAST  = CW'(WR_HIGH_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_IDLE,
    ST_SETUP,
    ST_WR_LO,
    ST_WR_HI
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [24:0]     fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic            dc_q;
  logic [23:0]     data_q;

  logic            fifo_full, fifo_empty;
  logic            push_req, push, pop, sw_rst;
  logic            busy, in_reset;
  logic [8:0]      level_ext;
  logic [7:0]      level_sat;
  logic [31:0]     status;
  logic            unused_wdata;

  assign fifo_full  = (level_q == DEPTH_L);
  assign fifo_empty = (level_q == '0);

  // Addresses 0 and 1 both feed the FIFO; address bit 0 becomes dc.
  assign push_req = avs_write && !avs_address[1];
  assign push     = push_req && !fifo_full;
  assign sw_rst   = avs_write && (avs_address == 2'd2) && avs_writedata[0];

  // Stall uses the registered level, so a pop only frees the slot one cycle later.
  assign avs_waitrequest = reset_reset_n && push_req && fifo_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_WR_LO;
        cnt_d   = '0;
      end
      ST_WR_LO: begin
        if (cnt_q == LO_LAST) begin
          state_d = ST_WR_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (sw_rst) begin
      state_d = ST_RST_HOLD;
      cnt_d   = '0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= ST_RST_HOLD;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sw_rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push && reset_reset_n) fifo_mem_q[wr_ptr_q] <= {avs_address[0], avs_writedata[23:0]};
  end

  // Registered read port doubles as the bus hold register: it only loads on a pop.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      dc_q   <= 1'b1;
      data_q <= '0;
    end else if (pop) begin
      {dc_q, data_q} <= fifo_mem_q[rd_ptr_q];
    end
  end

  assign lcd_cs   = !((state_q == ST_SETUP) || (state_q == ST_WR_LO) || (state_q == ST_WR_HI));
  assign lcd_wr   = (state_q != ST_WR_LO);
  assign lcd_rst  = (state_q != ST_RST_HOLD);
  assign lcd_dc   = dc_q;
  assign lcd_data = data_q;

  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign in_reset  = (state_q == ST_RST_HOLD);
  assign level_ext = 9'(level_q);
  assign level_sat = level_ext[8] ? 8'hFF : level_ext[7:0];
  assign status    = {16'h0000, level_sat, 5'b00000, in_reset, fifo_full, busy};

  assign avs_readdata = (reset_reset_n && avs_read && (avs_address == 2'd2)) ? status : 32'h0;

  assign unused_wdata = ^avs_writedata[31:24];

endmodule

// File: tb/tb_lcd_8080_writer.sv
// Bench for lcd_8080_writer: table-driven single words plus burst, full-stall
// and reset sequences; a negedge monitor scores every latched word.
module tb_lcd_8080_writer;

  localparam int DEPTH  = 16;
  localparam int WLO    = 2;
  localparam int WHI    = 2;
  localparam int RSTC   = 20;
  localparam int PERIOD = 1 + WLO + WHI;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        lcd_cs, lcd_dc, lcd_rst, lcd_wr;
  logic [23:0] lcd_data;

  always #5 clk = ~clk;

  lcd_8080_writer #(
    .FIFO_DEPTH(DEPTH), .WR_LOW_CYCLES(WLO), .WR_HIGH_CYCLES(WHI), .RST_CYCLES(RSTC)
  ) dut (
    .clk_clk(clk), .reset_reset_n(reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .lcd_cs(lcd_cs), .lcd_data(lcd_data), .lcd_dc(lcd_dc), .lcd_rst(lcd_rst), .lcd_wr(lcd_wr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of {dc, data} words the panel should latch, in order.
  logic [24:0] exp_q[$];
  int   latched = 0;
  int   wr_low_samples = 0;
  logic prev_wr = 1'b1;
  int   low_len = 0;
  int   cyc = 0;
  int   last_latch = -1;
  bit   cs_high_since = 1'b1;

  always @(negedge clk) begin
    logic [24:0] e;
    cyc++;
    if (lcd_cs === 1'b1) cs_high_since = 1'b1;
    if (lcd_wr === 1'b0) begin
      low_len++;
      wr_low_samples++;
      chk("cs_low_during_wr", {31'b0, lcd_cs}, 32'h0);
    end
    if (prev_wr === 1'b0 && lcd_wr === 1'b1 && lcd_cs === 1'b0) begin
      latched++;
      chk("wr_low_len", low_len, WLO);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", {lcd_dc, lcd_data});
      end else begin
        e = exp_q.pop_front();
        chk("word", {7'b0, lcd_dc, lcd_data}, {7'b0, e});
        $display("word %0d latched dc=%0d data=0x%06h", latched, lcd_dc, lcd_data);
      end
      if (!cs_high_since && last_latch >= 0) chk("word_period", cyc - last_latch, PERIOD);
      last_latch    = cyc;
      cs_high_since = 1'b0;
    end
    if (lcd_wr !== 1'b0) low_len = 0;
    prev_wr = lcd_wr;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stall);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; stall = 0;
    @(negedge clk);
    while (avs_waitrequest === 1'b1 && stall < 2000) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 2000) chk("write_timeout", {31'b0, avs_waitrequest}, 32'h0);
    @(posedge clk);
    if (a == 2'd0 || a == 2'd1) exp_q.push_back({a[0], d[23:0]});
    #1 avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    d = avs_readdata;
    @(posedge clk);
    #1 avs_read = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    int n;
    n = 0;
    bus_read(2'd2, r);
    while (r[0] && n < 600) begin
      n++;
      bus_read(2'd2, r);
    end
    chk("idle_reached", {31'b0, r[0]}, 32'h0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_dc;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, base, lat, lw, total_stall;
    logic [31:0] r;
    logic prev_rst;

    vt[0] = '{1'b1, 2'd0, 32'h0000002C, 32'h0, 1'b0, 24'h00002C};
    vt[1] = '{1'b1, 2'd1, 32'hFFABCDEF, 32'h0, 1'b1, 24'hABCDEF};
    vt[2] = '{1'b1, 2'd0, 32'h12000000, 32'h0, 1'b0, 24'h000000};
    vt[3] = '{1'b1, 2'd1, 32'h00FFFFFF, 32'h0, 1'b1, 24'hFFFFFF};
    vt[4] = '{1'b0, 2'd0, 32'h0,        32'h0, 1'b0, 24'h0};
    vt[5] = '{1'b0, 2'd1, 32'h0,        32'h0, 1'b0, 24'h0};
    vt[6] = '{1'b0, 2'd3, 32'h0,        32'h0, 1'b0, 24'h0};
    vt[7] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, 1'b0, 24'h0};

    reset_n = 1'b0; avs_address = 2'd2; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs",   {31'b0, lcd_cs},  32'h1);
    chk("rst_wr",   {31'b0, lcd_wr},  32'h1);
    chk("rst_dc",   {31'b0, lcd_dc},  32'h1);
    chk("rst_data", {8'b0, lcd_data}, 32'h0);
    chk("rst_rst",  {31'b0, lcd_rst}, 32'h0);
    chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);

    // Power-up pulse: status read held every cycle while counting lcd_rst low.
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (lcd_rst === 1'b0 && n < 1000) begin
      n++;
      chk("pwr_status", avs_readdata, 32'h5);
      chk("pwr_cs", {31'b0, lcd_cs}, 32'h1);
      chk("pwr_wr", {31'b0, lcd_wr}, 32'h1);
      @(negedge clk);
    end
    chk("pwr_rst_len", n, RSTC);
    chk("pwr_status_after", avs_readdata, 32'h0);
    $display("power-up: lcd_rst low for %0d cycles", n);
    @(posedge clk);
    #1 avs_read = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_wr) begin
        bus_write(vt[i].addr, vt[i].wdata, st);
        if (vt[i].addr[1] == 1'b0) begin
          @(negedge clk);
          chk("lat_cs_n1", {31'b0, lcd_cs}, 32'h1);
          @(negedge clk);
          chk("lat_cs_n2", {31'b0, lcd_cs}, 32'h0);
          chk("lat_wr_n2", {31'b0, lcd_wr}, 32'h1);
          chk("lat_dc_n2", {31'b0, lcd_dc}, {31'b0, vt[i].exp_dc});
          chk("lat_data_n2", {8'b0, lcd_data}, {8'b0, vt[i].exp_data});
          @(negedge clk);
          chk("lat_wr_n3", {31'b0, lcd_wr}, 32'h0);
        end
        wait_idle();
        chk("vec_cs_idle", {31'b0, lcd_cs}, 32'h1);
        bus_read(2'd2, r);
        chk("vec_status", r, vt[i].exp_rd);
        $display("vec %0d write addr=%0d data=0x%08h status=0x%0h", i, vt[i].addr, vt[i].wdata, r);
      end else begin
        bus_read(vt[i].addr, r);
        chk("vec_read", r, vt[i].exp_rd);
        $display("vec %0d read addr=%0d data=0x%0h", i, vt[i].addr, r);
      end
    end
    chk("vec_queue_empty", exp_q.size(), 0);

    // Burst faster than the drain rate, so the FIFO fills and stalls.
    base = latched; total_stall = 0;
    for (int i = 1; i <= 24; i++) begin
      bus_write(2'd1, i, st);
      total_stall += st;
    end
    chk("burst_stalled", {31'b0, total_stall > 0}, 32'h1);
    wait_idle();
    chk("burst_words", latched - base, 24);
    chk("burst_queue_empty", exp_q.size(), 0);
    $display("burst: 24 words, %0d stall cycles", total_stall);

    // Fill during RST_HOLD, then a 17th write must wait for the first pop.
    base = latched; total_stall = 0;
    bus_write(2'd2, 32'h1, st);
    for (int i = 0; i < 16; i++) begin
      bus_write(2'd0, 32'h100 + i, st);
      total_stall += st;
    end
    chk("fill_no_stall", total_stall, 0);
    bus_read(2'd2, r);
    chk("full_status", r, 32'h1007);
    avs_address = 2'd0; avs_writedata = 32'h1FF; avs_write = 1'b1; n = 0; prev_rst = 1'b0;
    @(negedge clk);
    while (avs_waitrequest === 1'b1 && n < 1000) begin
      prev_rst = lcd_rst;
      n++;
      @(negedge clk);
    end
    chk("full_stall_seen", {31'b0, n > 0}, 32'h1);
    chk("stall_end_after_idle", {31'b0, prev_rst}, 32'h1);
    chk("stall_end_in_setup", {31'b0, lcd_cs}, 32'h0);
    @(posedge clk);
    exp_q.push_back({1'b0, 24'h0001FF});
    #1 avs_write = 1'b0;
    wait_idle();
    chk("full_words", latched - base, 17);
    chk("full_queue_empty", exp_q.size(), 0);
    $display("full-stall: 17th write stalled %0d cycles", n);

    // Software reset during WR_LO of the third queued word.
    base = latched;
    for (int i = 0; i < 8; i++) bus_write(2'd1, 32'hA0 + i, st);
    n = 0;
    @(negedge clk);
    while (!((latched - base) == 2 && lcd_wr === 1'b0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("swr_found_wr_lo", {31'b0, n < 500}, 32'h1);
    avs_address = 2'd2; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk);
    exp_q.delete();
    lw = wr_low_samples; lat = latched;
    #1 avs_write = 1'b0; avs_read = 1'b1;
    n = 0;
    @(negedge clk);
    chk("swr_wr", {31'b0, lcd_wr}, 32'h1);
    chk("swr_cs", {31'b0, lcd_cs}, 32'h1);
    chk("swr_status", avs_readdata, 32'h5);
    while (lcd_rst === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("swr_rst_len", n, RSTC);
    @(posedge clk);
    #1 avs_read = 1'b0;
    repeat (30) @(negedge clk);
    chk("swr_no_latch", latched - lat, 0);
    chk("swr_no_wr_pulse", wr_low_samples - lw, 0);
    $display("sw reset: lcd_rst low %0d cycles, no further pulses", n);

    // Synchronous reset asserted during WR_LO.
    bus_write(2'd0, 32'h00BEEF, st);
    n = 0;
    @(negedge clk);
    while (lcd_wr !== 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("srst_found_wr_lo", {31'b0, n < 100}, 32'h1);
    reset_n = 1'b0; avs_read = 1'b1; avs_address = 2'd2;
    @(negedge clk);
    exp_q.delete();
    chk("srst_cs",   {31'b0, lcd_cs},  32'h1);
    chk("srst_wr",   {31'b0, lcd_wr},  32'h1);
    chk("srst_rst",  {31'b0, lcd_rst}, 32'h0);
    chk("srst_data", {8'b0, lcd_data}, 32'h0);
    chk("srst_dc",   {31'b0, lcd_dc},  32'h1);
    chk("srst_readdata", avs_readdata, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("srst_status_level0", avs_readdata, 32'h5);
    @(posedge clk);
    #1 avs_read = 1'b0;
    wait_idle();
    chk("srst_queue_empty", exp_q.size(), 0);
    $display("sync reset: outputs returned to reset values");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
